// File: rtl/hub75_rx.sv
// HUB75 receive monitor: oversamples the panel bus, shifts one column per sclk rise
// and commits each latched row into a readable frame store.
module hub75_rx #(
    parameter int COLS  = 64,
    parameter int ROWS  = 16,
    parameter int ROW_W = 4,
    parameter int COL_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             lat,
    input  logic [ROW_W-1:0] row_addr,
    input  logic [2:0]       rgb0,
    input  logic [2:0]       rgb1,
    input  logic             rd_en,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    output logic             rd_valid,
    output logic [2:0]       rd_rgb0,
    output logic [2:0]       rd_rgb1,
    output logic             frame_done,
    output logic             row_err,
    input  logic             err_clr
);

    localparam int CNT_W = $clog2(COLS + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    logic             sclk_q, sclk_qq, lat_q, lat_qq;
    logic [ROW_W-1:0] row_q;
    logic [2:0]       rgb0_q, rgb1_q;
    logic             sclk_rise_s, lat_rise_s;

    state_t           state_r, next_state_s;
    logic             commit_s, row_ok_s;
    logic [ROW_W-1:0] commit_row_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [COLS-1:0][2:0] sr0_r, sr1_r;
    logic [ROWS-1:0]  row_vld_r;
    logic [COLS-1:0][2:0] mem0 [ROWS];
    logic [COLS-1:0][2:0] mem1 [ROWS];

    // Input sampling stage plus second flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q  <= 1'b0;
            sclk_qq <= 1'b0;
            lat_q   <= 1'b0;
            lat_qq  <= 1'b0;
            row_q   <= {ROW_W{1'b0}};
            rgb0_q  <= 3'b000;
            rgb1_q  <= 3'b000;
        end else begin
            sclk_q  <= sclk;
            sclk_qq <= sclk_q;
            lat_q   <= lat;
            lat_qq  <= lat_q;
            row_q   <= row_addr;
            rgb0_q  <= rgb0;
            rgb1_q  <= rgb1;
        end
    end

    assign sclk_rise_s = sclk_q & ~sclk_qq;
    assign lat_rise_s  = lat_q & ~lat_qq;
    assign row_ok_s    = commit_s && (bit_cnt_r == CNT_W'(COLS));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state; a lat rise during COMMIT is deliberately ignored.
    always_comb begin
        next_state_s = state_r;
        commit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (lat_rise_s) begin
                    next_state_s = COMMIT;
                end else if (sclk_rise_s) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (lat_rise_s) begin
                    next_state_s = COMMIT;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            COMMIT: begin
                commit_s = 1'b1;
                if (sclk_rise_s) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Shift registers, saturating column count and the row latched at lat rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr0_r        <= '0;
            sr1_r        <= '0;
            bit_cnt_r    <= {CNT_W{1'b0}};
            commit_row_r <= {ROW_W{1'b0}};
        end else begin
            if (sclk_rise_s) begin
                sr0_r <= {sr0_r[COLS-2:0], rgb0_q};
                sr1_r <= {sr1_r[COLS-2:0], rgb1_q};
            end
            if (commit_s) begin
                // A shift landing in the commit cycle is the first bit of the next row.
                bit_cnt_r <= sclk_rise_s ? CNT_W'(1) : CNT_W'(0);
            end else if (sclk_rise_s && (bit_cnt_r != CNT_W'(COLS + 1))) begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
            if (lat_rise_s && (state_r != COMMIT)) begin
                commit_row_r <= row_q;
            end
        end
    end

    // Commit bookkeeping: row validity, frame pulse, sticky length error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_vld_r  <= {ROWS{1'b0}};
            frame_done <= 1'b0;
            row_err    <= 1'b0;
        end else begin
            frame_done <= commit_s && (commit_row_r == ROW_W'(ROWS - 1));
            if (row_ok_s) begin
                row_vld_r[commit_row_r] <= 1'b1;
            end
            if (commit_s && !row_ok_s) begin
                row_err <= 1'b1;
            end else if (err_clr) begin
                row_err <= 1'b0;
            end
        end
    end

    // Frame store; unreset, contents masked by row_vld_r.
    always_ff @(posedge clk) begin
        if (row_ok_s) begin
            mem0[commit_row_r] <= sr0_r;
            mem1[commit_row_r] <= sr1_r;
        end
    end

    // Registered read port; column 0 is the oldest shifted entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_rgb0  <= 3'b000;
            rd_rgb1  <= 3'b000;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_rgb0 <= row_vld_r[rd_row] ? mem0[rd_row][~rd_col] : 3'b000;
                rd_rgb1 <= row_vld_r[rd_row] ? mem1[rd_row][~rd_col] : 3'b000;
            end
        end
    end

endmodule
